argmin_selector: RTL and testbench

ARGMIN_SELECTOR -- requirements
Module: argmin_selector

---
 rtl/argmin_selector.sv | 95 +++++++++
 tb/tb_argmin_selector.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/argmin_selector.sv
// Streams K squared distances per data point and reports the index and value
// of the smallest one, holding the result until downstream accepts it.
module argmin_selector #(
  parameter int K     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             dist_valid,
  output logic             dist_ready,
  input  logic [31:0]      dist_sq,
  output logic             label_valid,
  input  logic             label_ready,
  output logic [IDX_W-1:0] label,
  output logic [31:0]      min_dist,
  output logic [15:0]      points_done
);

  localparam int unsigned DIST_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              state_q, state_nxt;
  logic [IDX_W-1:0]    cnt_q, cnt_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic [DIST_W-1:0]   min_nxt;
  logic [CNT_W-1:0]    points_nxt;
  logic                accept;

  // Next-state and running-minimum update; clear outranks both handshakes.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    idx_nxt    = label;
    min_nxt    = min_dist;
    points_nxt = points_done;
    accept     = dist_valid && dist_ready;

    if (clear) begin
      state_nxt = ACCUM;
      cnt_nxt   = '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q == '0) begin
              min_nxt = dist_sq;
              idx_nxt = '0;
            end else if (dist_sq < min_dist) begin
              min_nxt = dist_sq;
              idx_nxt = cnt_q;
            end
            if (cnt_q == IDX_W'(K - 1)) begin
              cnt_nxt   = '0;
              state_nxt = HOLD;
            end else begin
              cnt_nxt = cnt_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (label_ready) begin
            state_nxt  = ACCUM;
            points_nxt = points_done + CNT_W'(1);
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // Running min/index double as the presented result; they are frozen in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      label       <= '0;
      min_dist    <= '0;
      points_done <= '0;
      label_valid <= 1'b0;
      dist_ready  <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      label       <= idx_nxt;
      min_dist    <= min_nxt;
      points_done <= points_nxt;
      label_valid <= (state_nxt == HOLD);
      dist_ready  <= (state_nxt == ACCUM);
    end
  end

endmodule

// File: tb/tb_argmin_selector.sv
// Directed bench for argmin_selector: vector table of K=4 points plus
// clear, reset and points_done wrap sequences.
module tb_argmin_selector;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        dist_valid;
  logic        dist_ready;
  logic [31:0] dist_sq;
  logic        label_valid;
  logic        label_ready;
  logic [1:0]  label;
  logic [31:0] min_dist;
  logic [15:0] points_done;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_points = 16'd0;

  argmin_selector #(.K(4), .IDX_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .dist_valid  (dist_valid),
    .dist_ready  (dist_ready),
    .dist_sq     (dist_sq),
    .label_valid (label_valid),
    .label_ready (label_ready),
    .label       (label),
    .min_dist    (min_dist),
    .points_done (points_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d [4];
    int          gap;
    int          hold;
    logic [31:0] exp_label;
    logic [31:0] exp_min;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input int gap, input int hold,
                              input logic [31:0] lbl, input logic [31:0] mn);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.gap = gap; v.hold = hold; v.exp_label = lbl; v.exp_min = mn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the distance is accepted.
  task automatic send(input logic [31:0] x);
    int n = 0;
    dist_valid = 1'b1;
    dist_sq    = x;
    while (!dist_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dist_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: dist_ready stuck at 0 for %0d cycles", n);
    end
    @(negedge clk);
    dist_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    for (int i = 0; i < 4; i++) begin
      send(v.d[i]);
      if (i < 3) repeat (v.gap) @(negedge clk);
    end
    chk({name, ".valid"}, 32'(label_valid), 32'd1);
    chk({name, ".label"}, 32'(label), v.exp_label);
    chk({name, ".min"}, min_dist, v.exp_min);
    chk({name, ".ready_in_hold"}, 32'(dist_ready), 32'd0);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({name, ".hold_valid"}, 32'(label_valid), 32'd1);
      chk({name, ".hold_label"}, 32'(label), v.exp_label);
      chk({name, ".hold_min"}, min_dist, v.exp_min);
      chk({name, ".hold_ready"}, 32'(dist_ready), 32'd0);
    end
    label_ready = 1'b1;
    @(negedge clk);
    label_ready = 1'b0;
    exp_points  = exp_points + 16'd1;
    chk({name, ".valid_drop"}, 32'(label_valid), 32'd0);
    chk({name, ".ready_back"}, 32'(dist_ready), 32'd1);
    chk({name, ".points"}, 32'(points_done), 32'(exp_points));
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".valid"}, 32'(label_valid), 32'd0);
    chk({name, ".label"}, 32'(label), 32'd0);
    chk({name, ".min"}, min_dist, 32'd0);
    chk({name, ".points"}, 32'(points_done), 32'd0);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = mk(32'd50, 32'd20, 32'd30, 32'd40, 0, 0, 32'd1, 32'd20);
    vecs[1] = mk(32'd7, 32'd7, 32'd3, 32'd3, 0, 0, 32'd2, 32'd3);
    vecs[2] = mk(32'd10, 32'd9, 32'd8, 32'd1, 0, 5, 32'd3, 32'd1);
    vecs[3] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 0, 32'd0, 32'hFFFFFFFF);
    vecs[4] = mk(32'd5, 32'd4, 32'd4, 32'd9, 1, 1, 32'd1, 32'd4);
    vecs[5] = mk(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0);
    vecs[6] = mk(32'd9, 32'd8, 32'd7, 32'd6, 0, 2, 32'd3, 32'd6);
    vecs[7] = mk(32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'd0, 32'hFFFFFFFE);

    rst = 1'b1; clear = 1'b0; dist_valid = 1'b0; dist_sq = '0; label_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready", 32'(dist_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort a partial point; a distance offered during clear must be dropped.
    send(32'd1);
    send(32'd2);
    clear = 1'b1; dist_valid = 1'b1; dist_sq = 32'd0;
    @(negedge clk);
    clear = 1'b0; dist_valid = 1'b0;
    chk("clear.valid", 32'(label_valid), 32'd0);
    chk("clear.ready", 32'(dist_ready), 32'd1);
    run_vec(mk(32'd100, 32'd200, 32'd5, 32'd300, 0, 0, 32'd2, 32'd5), "after_clear");

    // Clear wins over a result handshake in the same cycle; no count.
    send(32'd6); send(32'd5); send(32'd4); send(32'd3);
    chk("clr_hold.valid_pre", 32'(label_valid), 32'd1);
    clear = 1'b1; label_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; label_ready = 1'b0;
    chk("clr_hold.valid", 32'(label_valid), 32'd0);
    chk("clr_hold.ready", 32'(dist_ready), 32'd1);
    chk("clr_hold.points", 32'(points_done), 32'(exp_points));

    // points_done wrap from 0xFFFF.
    force dut.points_done = 16'hFFFF;
    #1;
    release dut.points_done;
    exp_points = 16'hFFFF;
    @(negedge clk);
    run_vec(mk(32'd3, 32'd2, 32'd1, 32'd4, 0, 0, 32'd2, 32'd1), "wrap");
    run_vec(mk(32'd8, 32'd2, 32'd9, 32'd2, 0, 0, 32'd1, 32'd2), "post_wrap");

    // Reset in the middle of a point discards everything.
    send(32'd1);
    send(32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    rst = 1'b0;
    exp_points = 16'd0;
    @(negedge clk);
    chk("mid_reset.ready", 32'(dist_ready), 32'd1);
    run_vec(mk(32'd9, 32'd8, 32'd7, 32'd10, 0, 0, 32'd2, 32'd7), "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
